apb_mem_slave_p: RTL and testbench

//  Parametrised APB (v2/APB4-style) slave memory, successor to our fixed 8-bit x16 APB slave.

---
 rtl/apb_mem_slave_p.sv | 138 +++++++++++++
 tb/tb_apb_mem_slave_p.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave_p.sv
// APB slave memory: configurable width/depth, byte strobes, programmable wait states,
// address-error response, protocol-error response and transfer abort.
module apb_mem_slave_p #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                pclk,
    input  logic                prset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic                pready,
    output logic [DATA_W-1:0]   prdata,
    output logic                pslverr
);

    localparam int unsigned     NBytes  = DATA_W / 8;
    localparam int unsigned     ByteOff = $clog2(NBytes);
    localparam int unsigned     IdxW    = $clog2(DEPTH);
    localparam logic [3:0]      WaitCnt = 4'(WAIT_STATES);
    // Works for DATA_W=8 too, where there are no byte-offset bits.
    localparam logic [ADDR_W-1:0] LowMask = ADDR_W'((64'd1 << ByteOff) - 64'd1);
    localparam logic [ADDR_W-1:0] DepthA  = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              aerr_q, aerr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [ADDR_W-1:0] word_addr;
    logic              addr_err;
    logic              complete;

    assign word_addr = paddr >> ByteOff;
    assign addr_err  = (word_addr >= DepthA) || ((paddr & LowMask) != '0);

    // FSM next-state, transfer attribute latching and handshake outputs.
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        idx_d    = idx_q;
        aerr_d   = aerr_q;
        cnt_d    = cnt_q;
        pready   = 1'b0;
        pslverr  = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (psel && !penable) begin
                    state_d = StSetup;
                end else if (psel && penable) begin
                    // Access phase without a setup phase: reject, touch nothing.
                    pready  = 1'b1;
                    pslverr = 1'b1;
                end
            end
            StSetup: begin
                write_d = pwrite;
                idx_d   = word_addr[IdxW-1:0];
                aerr_d  = addr_err;
                cnt_d   = '0;
                if (!psel) begin
                    state_d = StIdle;
                end else if (penable) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (!psel) begin
                    state_d = StIdle;
                end else if (cnt_q != WaitCnt) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    complete = 1'b1;
                    pready   = 1'b1;
                    pslverr  = aerr_q;
                    state_d  = penable ? StIdle : StSetup;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read data is only driven in a good read completion cycle.
    always_comb begin
        prdata = '0;
        if (complete && !write_q && !aerr_q) begin
            prdata = mem_q[idx_q];
        end
    end

    // Byte-strobed write of the latched word on a good write completion.
    always_comb begin
        mem_d = mem_q;
        if (complete && write_q && !aerr_q) begin
            for (int unsigned b = 0; b < NBytes; b++) begin
                if (pstrb[b]) begin
                    mem_d[idx_q][8*b +: 8] = pwdata[8*b +: 8];
                end
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge pclk) begin
        if (!prset) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            idx_q   <= '0;
            aerr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            aerr_q  <= aerr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is not cleared by reset, but a write coinciding with reset is dropped.
    always_ff @(posedge pclk) begin
        if (prset) begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Bench for apb_mem_slave_p: one instance with two wait states and one zero-wait instance,
// driven by a master task, checked by a queue-based scoreboard against a word-array model.
module tb_apb_mem_slave_p;

    typedef struct {
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    logic        pclk = 1'b0;
    logic        prset;
    logic        psel_a, psel_b, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic        pready_a, pslverr_a, pready_b, pslverr_b;
    logic [31:0] prdata_a, prdata_b;

    int          checks = 0;
    int          errors = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];
    int          cnt[2];
    logic [31:0] last_rd[2];
    logic [31:0] ref_mem[2][16];

    always #5 pclk = ~pclk;

    apb_mem_slave_p #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .WAIT_STATES(2)) dut_a (
        .pclk(pclk), .prset(prset), .psel(psel_a), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_a), .prdata(prdata_a), .pslverr(pslverr_a)
    );

    apb_mem_slave_p #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .WAIT_STATES(0)) dut_b (
        .pclk(pclk), .prset(prset), .psel(psel_b), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_b), .prdata(prdata_b), .pslverr(pslverr_b)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Reference: a word is addressable iff aligned and below 16 words; latency counts the
    // penable cycles up to pready (one SETUP-state cycle plus WAIT_STATES+1 ACCESS cycles).
    function automatic exp_t model_xfer(input int w, input bit wr, input logic [31:0] addr,
                                        input logic [31:0] data, input logic [3:0] strb);
        exp_t e;
        bit   bad = (addr % 4 != 0) || (addr / 4 >= 16);
        int   idx = int'(addr / 4) % 16;
        e.err    = bad;
        e.chk_rd = !wr;
        e.lat    = (w == 0) ? 4 : 2;
        e.rdata  = (wr || bad) ? 32'h0 : ref_mem[w][idx];
        if (wr && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) ref_mem[w][idx][8*b +: 8] = data[8*b +: 8];
            end
        end
        return e;
    endfunction

    task automatic push(input int w, input exp_t e);
        if (w == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    task automatic setsel(input int w, input logic v);
        if (w == 0) psel_a = v;
        else        psel_b = v;
    endtask

    task automatic mon_step(input int w, input logic rdy, input logic [31:0] rd,
                            input logic err, input logic sel);
        exp_t e;
        bit   have;
        if (!prset) begin
            cnt[w] = 0;
            return;
        end
        if (sel && penable) cnt[w]++;
        if (rdy) begin
            have = (w == 0) ? (q_a.size() != 0) : (q_b.size() != 0);
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pready dut=%0d actual=1 required=0", w);
            end else begin
                if (w == 0) e = q_a.pop_front();
                else        e = q_b.pop_front();
                chk($sformatf("pslverr%0d", w), 32'(err), 32'(e.err));
                if (e.chk_rd) begin
                    chk($sformatf("prdata%0d", w), rd, e.rdata);
                    last_rd[w] = rd;
                end
                chk($sformatf("latency%0d", w), 32'(cnt[w]), 32'(e.lat));
            end
            cnt[w] = 0;
        end else begin
            chk($sformatf("idle_prdata%0d", w), rd, 32'h0);
            chk($sformatf("idle_pslverr%0d", w), 32'(err), 32'h0);
        end
        if (!sel) cnt[w] = 0;
    endtask

    always @(negedge pclk) mon_step(0, pready_a, prdata_a, pslverr_a, psel_a);
    always @(negedge pclk) mon_step(1, pready_b, prdata_b, pslverr_b, psel_b);

    // Full transfer; scr scrambles paddr/pwrite once the setup values have been taken.
    task automatic xfer(input int w, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input bit scr);
        int n = 0;
        bit done = 0;
        push(w, model_xfer(w, wr, addr, data, strb));
        setsel(w, 1'b1);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        @(posedge pclk); #1;
        penable = 1'b1;
        while (!done && n < 40) begin
            @(negedge pclk);
            if ((w == 0) ? pready_a : pready_b) begin
                done = 1;
            end else begin
                n++;
                @(posedge pclk); #1;
                if (scr) begin
                    paddr  = $urandom;
                    pwrite = 1'($urandom);
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout dut=%0d actual=no_pready required=pready", w);
            if (w == 0) void'(q_a.pop_front());
            else        void'(q_b.pop_front());
        end
        @(posedge pclk); #1;
        setsel(w, 1'b0);
        penable = 1'b0;
    endtask

    // Write that is abandoned after pen_cycles penable cycles, by psel drop or by reset.
    task automatic abort_xfer(input int w, input logic [31:0] addr, input logic [31:0] data,
                              input int pen_cycles, input bit by_reset);
        setsel(w, 1'b1);
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = addr;
        pwdata  = data;
        pstrb   = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (pen_cycles) @(posedge pclk);
        #1;
        if (by_reset) begin
            prset = 1'b0;
            @(posedge pclk); #1;
            prset = 1'b1;
        end
        setsel(w, 1'b0);
        penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic proto_err(input int w);
        exp_t e;
        e.err = 1'b1; e.chk_rd = 1'b0; e.rdata = 32'h0; e.lat = 1;
        push(w, e);
        setsel(w, 1'b1);
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h0;
        pwdata  = $urandom;
        pstrb   = 4'hF;
        @(posedge pclk); #1;
        setsel(w, 1'b0);
        penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] old;
        logic [31:0] addr;
        int          w, r;
        prset = 1'b0; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge pclk);
        #1 prset = 1'b1;
        @(posedge pclk); #1;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) xfer(d, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0);
        end

        xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 1'b0);
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0);
        chk("t1_rdata", last_rd[0], 32'hDEADBEEF);

        xfer(0, 1'b1, 32'h00, 32'h11223344, 4'hF, 1'b0);
        xfer(0, 1'b1, 32'h00, 32'hAABBCCDD, 4'b0101, 1'b0);
        xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 1'b0);
        chk("t2_strobe", last_rd[0], 32'h11BB33DD);

        xfer(0, 1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0);
        xfer(0, 1'b1, 32'h06, 32'h87654321, 4'hF, 1'b0);
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0);

        old = ref_mem[0][3];
        xfer(0, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'h0, 1'b0);
        xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, 1'b0);
        chk("strb0_unchanged", last_rd[0], old);

        xfer(1, 1'b1, 32'h3C, 32'h5A5A5A5A, 4'hF, 1'b0);
        xfer(1, 1'b0, 32'h3C, 32'h0, 4'h0, 1'b0);
        chk("t4_zero_wait", last_rd[1], 32'h5A5A5A5A);

        old = ref_mem[0][4];
        abort_xfer(0, 32'h10, 32'hCAFEF00D, 2, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        chk("t5_psel_abort", last_rd[0], old);
        abort_xfer(0, 32'h10, 32'hCAFEF00D, 3, 1'b1);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        chk("t5_reset_abort", last_rd[0], old);

        old = ref_mem[0][0];
        proto_err(0);
        xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 1'b0);
        chk("t6_proto_mem", last_rd[0], old);
        proto_err(1);
        xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, 1'b0);

        repeat (300) begin
            w = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r == 0)      addr = 32'($urandom_range(16, 20)) << 2;
            else if (r == 1) addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else             addr = 32'($urandom_range(0, 15)) << 2;
            xfer(w, 1'($urandom), addr, $urandom, 4'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge pclk); #1;
            end
        end

        repeat (3) @(posedge pclk);
        chk("drain_a", 32'(q_a.size()), 32'h0);
        chk("drain_b", 32'(q_b.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
